// File: rtl/role_dealer_pkg.sv
// Shared constants, role codes and state encoding for the role dealer and game FSM.
package role_dealer_pkg;

  localparam int unsigned N_PLAYERS   = 5;
  localparam int unsigned ROLE_W      = 2;
  localparam int unsigned ROLE_WORD_W = ROLE_W * N_PLAYERS;
  localparam int unsigned SEED_COUNT  = 20;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned PLAYER_W    = 3;

  localparam logic [PLAYER_W-1:0] NO_PLAYER   = 3'd7;
  localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(N_PLAYERS - 1);

  typedef enum logic [ROLE_W-1:0] {
    ROLE_VILLAGER = 2'b00,
    ROLE_WOLF     = 2'b01,
    ROLE_DOCTOR   = 2'b10,
    ROLE_ILLEGAL  = 2'b11
  } role_e;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StLatch,
    StReveal,
    StDone,
    StError
  } state_e;

  // Player 0 sits in the most significant field of the role word.
  function automatic logic [ROLE_W-1:0] role_of(input logic [ROLE_WORD_W-1:0] word,
                                                input logic [PLAYER_W-1:0]    player);
    role_of = ROLE_VILLAGER;
    for (int unsigned p = 0; p < N_PLAYERS; p++) begin
      if (player == PLAYER_W'(p)) begin
        role_of = word[ROLE_WORD_W-1-ROLE_W*p -: ROLE_W];
      end
    end
  endfunction

endpackage

// File: rtl/role_decode.sv
// Combinational role-word checker: finds the wolf and doctor and flags malformed words.
module role_decode
  import role_dealer_pkg::*;
(
  input  logic [ROLE_WORD_W-1:0] roles,
  output logic [PLAYER_W-1:0]    wolf_id,
  output logic [PLAYER_W-1:0]    doctor_id,
  output logic                   valid
);

  logic [PLAYER_W-1:0] n_wolf;
  logic [PLAYER_W-1:0] n_doctor;
  logic                illegal;

  always_comb begin
    wolf_id   = NO_PLAYER;
    doctor_id = NO_PLAYER;
    n_wolf    = '0;
    n_doctor  = '0;
    illegal   = 1'b0;
    for (int unsigned p = 0; p < N_PLAYERS; p++) begin
      unique case (role_e'(roles[ROLE_WORD_W-1-ROLE_W*p -: ROLE_W]))
        ROLE_WOLF: begin
          wolf_id = PLAYER_W'(p);
          n_wolf  = n_wolf + PLAYER_W'(1);
        end
        ROLE_DOCTOR: begin
          doctor_id = PLAYER_W'(p);
          n_doctor  = n_doctor + PLAYER_W'(1);
        end
        ROLE_ILLEGAL:  illegal = 1'b1;
        ROLE_VILLAGER: ;
      endcase
    end
    valid = (n_wolf == PLAYER_W'(1)) && (n_doctor == PLAYER_W'(1)) && !illegal;
    // Never report a partial result from a rejected word.
    if (!valid) begin
      wolf_id   = NO_PLAYER;
      doctor_id = NO_PLAYER;
    end
  end

endmodule

// File: rtl/role_dealer.sv
// Deals roles for a 5-player round from a seed ROM and steps through a private reveal.
module role_dealer
  import role_dealer_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   next,
  output logic [ADDR_W-1:0]      rom_address,
  input  logic [ROLE_WORD_W-1:0] rom_data,
  output logic [ROLE_WORD_W-1:0] roles,
  output logic [PLAYER_W-1:0]    wolf_id,
  output logic [PLAYER_W-1:0]    doctor_id,
  output logic [PLAYER_W-1:0]    reveal_player,
  output logic [ROLE_W-1:0]      reveal_role,
  output logic                   reveal_valid,
  output logic                   busy,
  output logic                   dealt,
  output logic                   error
);

  state_e              state;
  logic [ADDR_W-1:0]   seed_cnt;
  logic [PLAYER_W-1:0] dec_wolf;
  logic [PLAYER_W-1:0] dec_doctor;
  logic                dec_valid;

  role_decode u_decode (
    .roles    (rom_data),
    .wolf_id  (dec_wolf),
    .doctor_id(dec_doctor),
    .valid    (dec_valid)
  );

  // Free-running so the seed depends only on when the start button is pressed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seed_cnt <= '0;
    end else if (seed_cnt == ADDR_W'(SEED_COUNT - 1)) begin
      seed_cnt <= '0;
    end else begin
      seed_cnt <= seed_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      rom_address   <= '0;
      roles         <= '0;
      wolf_id       <= NO_PLAYER;
      doctor_id     <= NO_PLAYER;
      reveal_player <= '0;
      reveal_valid  <= 1'b0;
      busy          <= 1'b0;
      dealt         <= 1'b0;
      error         <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone, StError: begin
          if (start) begin
            rom_address <= seed_cnt;
            dealt       <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b1;
            state       <= StWait;
          end
        end
        StWait: state <= StLatch;
        StLatch: begin
          roles     <= rom_data;
          wolf_id   <= dec_wolf;
          doctor_id <= dec_doctor;
          if (dec_valid) begin
            reveal_player <= '0;
            reveal_valid  <= 1'b1;
            state         <= StReveal;
          end else begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= StError;
          end
        end
        StReveal: begin
          if (next) begin
            if (reveal_player == LAST_PLAYER) begin
              reveal_valid <= 1'b0;
              dealt        <= 1'b1;
              busy         <= 1'b0;
              state        <= StDone;
            end else begin
              reveal_player <= reveal_player + PLAYER_W'(1);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign reveal_role = role_of(roles, reveal_player);

endmodule

// File: tb/tb_role_dealer.sv
// Directed bench for role_dealer with a registered seed ROM model.
module tb_role_dealer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       next  = 1'b0;
  logic [4:0] rom_address;
  logic [9:0] rom_data;
  logic [9:0] roles;
  logic [2:0] wolf_id;
  logic [2:0] doctor_id;
  logic [2:0] reveal_player;
  logic [1:0] reveal_role;
  logic       reveal_valid;
  logic       busy;
  logic       dealt;
  logic       error;

  int checks   = 0;
  int failures = 0;
  int seed_m;

  role_dealer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .next         (next),
    .rom_address  (rom_address),
    .rom_data     (rom_data),
    .roles        (roles),
    .wolf_id      (wolf_id),
    .doctor_id    (doctor_id),
    .reveal_player(reveal_player),
    .reveal_role  (reveal_role),
    .reveal_valid (reveal_valid),
    .busy         (busy),
    .dealt        (dealt),
    .error        (error)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] rom_word(input logic [4:0] a);
    case (a)
      5'd0:    rom_word = 10'b01_10_00_00_00;
      5'd5:    rom_word = 10'b01_01_00_00_00;
      5'd6:    rom_word = 10'b11_01_10_00_00;
      5'd7:    rom_word = 10'b00_00_01_00_10;
      5'd19:   rom_word = 10'b00_00_00_10_01;
      default: rom_word = 10'b10_01_00_00_00;
    endcase
  endfunction

  always @(posedge clock) rom_data <= rom_word(rom_address);

  // Reference seed counter: its value at a falling edge is what the next rising edge samples.
  always @(posedge clock or posedge reset) begin
    if (reset) seed_m <= 0;
    else       seed_m <= (seed_m == 19) ? 0 : seed_m + 1;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_at(input int k);
    int n;
    n = 0;
    while (seed_m != k && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL start_at_bound seed=%0d wanted=%0d", seed_m, k);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({rom_address, roles, wolf_id, doctor_id, reveal_player, reveal_role,
         reveal_valid, busy, dealt, error} !==
        {5'd0, 10'd0, 3'd7, 3'd7, 3'd0, 2'd0, 4'b0000}) begin
      failures++;
      $display("FAIL reset_values got=%h %h %0d %0d %0d %b %b%b%b%b exp=00 000 7 7 0 00 0000",
               rom_address, roles, wolf_id, doctor_id, reveal_player, reveal_role,
               reveal_valid, busy, dealt, error);
    end
    reset = 1'b0;
    tick();
    pulse_next();
    checks++;
    if ({busy, reveal_valid, reveal_player} !== {1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL idle_next_ignored got busy=%b rv=%b rp=%0d exp 0 0 0",
               busy, reveal_valid, reveal_player);
    end
  endtask

  task automatic test_deal_seed0();
    start_at(0);
    checks++;
    if ({rom_address, busy, reveal_valid} !== {5'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL deal0_wait got addr=%0d busy=%b rv=%b exp 0 1 0",
               rom_address, busy, reveal_valid);
    end
    tick();
    checks++;
    if ({busy, reveal_valid} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL deal0_latch got busy=%b rv=%b exp 1 0", busy, reveal_valid);
    end
    tick();
    checks++;
    if ({roles, wolf_id, doctor_id, reveal_valid, reveal_player, reveal_role, busy, error,
         dealt} !== {10'b01_10_00_00_00, 3'd0, 3'd1, 1'b1, 3'd0, 2'b01, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL deal0_result got roles=%b w=%0d d=%0d rv=%b rp=%0d rr=%b b=%b e=%b dl=%b",
               roles, wolf_id, doctor_id, reveal_valid, reveal_player, reveal_role, busy,
               error, dealt);
    end
  endtask

  task automatic test_reveal(input logic [9:0] word);
    logic [1:0] exp_role;
    for (int i = 0; i < 5; i++) begin
      exp_role = word[9-2*i -: 2];
      checks++;
      if ({reveal_player, reveal_role, reveal_valid} !== {3'(i), exp_role, 1'b1}) begin
        failures++;
        $display("FAIL reveal_step%0d got rp=%0d rr=%b rv=%b exp rp=%0d rr=%b rv=1",
                 i, reveal_player, reveal_role, reveal_valid, i, exp_role);
      end
      pulse_next();
    end
    checks++;
    if ({reveal_valid, dealt, busy, reveal_player} !== {1'b0, 1'b1, 1'b0, 3'd4}) begin
      failures++;
      $display("FAIL reveal_done got rv=%b dealt=%b busy=%b rp=%0d exp 0 1 0 4",
               reveal_valid, dealt, busy, reveal_player);
    end
    pulse_next();
    checks++;
    if ({reveal_valid, dealt, busy, reveal_player, roles} !==
        {1'b0, 1'b1, 1'b0, 3'd4, word}) begin
      failures++;
      $display("FAIL extra_next got rv=%b dealt=%b busy=%b rp=%0d roles=%b exp 0 1 0 4 %b",
               reveal_valid, dealt, busy, reveal_player, roles, word);
    end
  endtask

  task automatic test_deal_seed19();
    start_at(19);
    checks++;
    if ({rom_address, roles, wolf_id, doctor_id, dealt, busy} !==
        {5'd19, 10'b01_10_00_00_00, 3'd0, 3'd1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL deal19_hold got addr=%0d roles=%b w=%0d d=%0d dealt=%b busy=%b",
               rom_address, roles, wolf_id, doctor_id, dealt, busy);
    end
    tick();
    tick();
    checks++;
    if ({roles, wolf_id, doctor_id, reveal_valid, reveal_player} !==
        {10'b00_00_00_10_01, 3'd4, 3'd3, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL deal19_result got roles=%b w=%0d d=%0d rv=%b rp=%0d exp 0000001001 4 3 1 0",
               roles, wolf_id, doctor_id, reveal_valid, reveal_player);
    end
    test_reveal(10'b00_00_00_10_01);
  endtask

  task automatic test_error();
    start_at(5);
    tick();
    tick();
    checks++;
    if ({roles, wolf_id, doctor_id, error, busy, reveal_valid, dealt} !==
        {10'b01_01_00_00_00, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL two_wolves got roles=%b w=%0d d=%0d err=%b busy=%b rv=%b dealt=%b",
               roles, wolf_id, doctor_id, error, busy, reveal_valid, dealt);
    end
    pulse_next();
    checks++;
    if ({error, reveal_valid, busy} !== {1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL error_next_ignored got err=%b rv=%b busy=%b exp 1 0 0",
               error, reveal_valid, busy);
    end
    start_at(6);
    checks++;
    if ({error, wolf_id, doctor_id, busy} !== {1'b0, 3'd7, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL error_clear_on_start got err=%b w=%0d d=%0d busy=%b exp 0 7 7 1",
               error, wolf_id, doctor_id, busy);
    end
    tick();
    tick();
    checks++;
    if ({error, wolf_id, doctor_id, reveal_valid} !== {1'b1, 3'd7, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL illegal_code got err=%b w=%0d d=%0d rv=%b exp 1 7 7 0",
               error, wolf_id, doctor_id, reveal_valid);
    end
    start_at(7);
    tick();
    tick();
    checks++;
    if ({roles, wolf_id, doctor_id, error, reveal_valid, reveal_role} !==
        {10'b00_00_01_00_10, 3'd2, 3'd4, 1'b0, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL redeal_after_error got roles=%b w=%0d d=%0d err=%b rv=%b rr=%b",
               roles, wolf_id, doctor_id, error, reveal_valid, reveal_role);
    end
  endtask

  task automatic test_ignore_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({rom_address, reveal_valid, reveal_player, busy} !== {5'd7, 1'b1, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL reveal_start_ignored got addr=%0d rv=%b rp=%0d busy=%b exp 7 1 0 1",
               rom_address, reveal_valid, reveal_player, busy);
    end
    start = 1'b1;
    next  = 1'b1;
    tick();
    start = 1'b0;
    next  = 1'b0;
    checks++;
    if ({rom_address, reveal_player, reveal_role, reveal_valid} !==
        {5'd7, 3'd1, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL start_and_next got addr=%0d rp=%0d rr=%b rv=%b exp 7 1 00 1",
               rom_address, reveal_player, reveal_role, reveal_valid);
    end
    pulse_next();
    checks++;
    if ({reveal_player, reveal_role} !== {3'd2, 2'b01}) begin
      failures++;
      $display("FAIL reveal_p2 got rp=%0d rr=%b exp 2 01", reveal_player, reveal_role);
    end
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rom_address, roles, wolf_id, doctor_id, reveal_player, reveal_role,
         reveal_valid, busy, dealt, error} !==
        {5'd0, 10'd0, 3'd7, 3'd7, 3'd0, 2'd0, 4'b0000}) begin
      failures++;
      $display("FAIL async_reset got %h %h %0d %0d %0d %b %b%b%b%b exp 00 000 7 7 0 00 0000",
               rom_address, roles, wolf_id, doctor_id, reveal_player, reveal_role,
               reveal_valid, busy, dealt, error);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_wait_start();
    start_at(19);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({rom_address, busy, reveal_valid} !== {5'd19, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL wait_start_ignored got addr=%0d busy=%b rv=%b exp 19 1 0",
               rom_address, busy, reveal_valid);
    end
    tick();
    checks++;
    if ({rom_address, roles, wolf_id, doctor_id, reveal_valid, reveal_player} !==
        {5'd19, 10'b00_00_00_10_01, 3'd4, 3'd3, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL deal_after_reset got addr=%0d roles=%b w=%0d d=%0d rv=%b rp=%0d",
               rom_address, roles, wolf_id, doctor_id, reveal_valid, reveal_player);
    end
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    test_reset();
    test_deal_seed0();
    test_reveal(10'b01_10_00_00_00);
    test_deal_seed19();
    test_error();
    test_ignore_start();
    test_async_reset();
    test_wait_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timed out");
  end

endmodule
